instruction_register: RTL and testbench
=======================================

INSTRUCTION_REGISTER -- requirements
Module: instruction_register

Interface
REQ-001 Parameter IR_WIDTH, default 5, instruction register length in bits; legal range 3..8.
REQ-002 Parameter RESET_INSTR, default 5'b00001 (IDCODE encoding), instruction loaded on reset or Test-Logic-Reset.
REQ-003 TCK  input  1  sole clock; all state changes on rising edge.
REQ-004 TRST  input  1  reset, synchronous, active-high.
REQ-005 tlr  input  1  TAP is in Test-Logic-Reset state.
REQ-006 capture_ir  input  1  TAP is in Capture-IR state.
REQ-007 shift_ir  input  1  TAP is in Shift-IR state.
REQ-008 update_ir  input  1  TAP is in Update-IR state.
REQ-009 TDI  input  1  serial data in.
REQ-010 status_in  input  IR_WIDTH-2  design status sampled at capture; used only under IR_CAPTURE_STATUS_EN.
REQ-011 tdo_ir  output  1  serial data out, equals shift_reg[0].
REQ-012 parallel_out  output  IR_WIDTH  active instruction, fed to the instruction decoder.
REQ-013 ir_updated  output  1  one-cycle pulse, new instruction latched.
REQ-014 shift_cnt  output  4  number of bits shifted since the last capture, saturating at 15.

Function
REQ-015 Shift stage shift_reg[IR_WIDTH-1:0]; update stage upd_reg[IR_WIDTH-1:0] drives parallel_out directly.
REQ-016 Control priority per cycle, highest first: TRST, tlr, capture_ir, shift_ir, update_ir; lower-priority inputs are ignored when a higher one is asserted.
REQ-017 capture_ir: shift_reg <= {zeros, 2'b01}; shift_cnt <= 0; upd_reg unchanged.
REQ-018 shift_ir: shift_reg <= {TDI, shift_reg[IR_WIDTH-1:1]} (LSB first out); shift_cnt increments, saturating at 15.
REQ-019 tdo_ir is combinational from shift_reg[0]; it is valid in the same cycle shift_ir is asserted, before the shift edge.
REQ-020 update_ir: upd_reg <= shift_reg on the same edge; ir_updated = 1 on the following cycle only.
REQ-021 update_ir held for N consecutive cycles: upd_reg is reloaded each cycle; ir_updated pulses once per rising edge of update_ir only.
REQ-022 Shifting more than IR_WIDTH bits: the oldest bits fall off; shift_reg holds the last IR_WIDTH TDI bits.
REQ-023 Shifting fewer than IR_WIDTH bits before update: the partial contents are latched unchanged; no error masking.
REQ-024 parallel_out changes only on update_ir, tlr or TRST; capture and shift never disturb it.
REQ-025 tlr: upd_reg <= RESET_INSTR; shift_reg <= {zeros, 2'b01}; shift_cnt <= 0; ir_updated <= 0.

Reset
REQ-026 TRST=1 at a rising edge: upd_reg=RESET_INSTR, shift_reg={zeros,2'b01}, shift_cnt=0, ir_updated=0, hence tdo_ir=1.
REQ-027 TRST asserted mid-shift or coincident with update_ir: reset wins and the in-flight instruction is discarded.

Configuration
REQ-028 Macro IR_CAPTURE_STATUS_EN defined: capture loads shift_reg <= {status_in, 2'b01}.
REQ-029 Macro IR_CAPTURE_STATUS_EN undefined: capture loads {zeros, 2'b01}; status_in is unused; the two LSBs are always 2'b01.

Verification
REQ-030 Reset: TRST=1 for one cycle -> parallel_out=5'b00001, tdo_ir=1, shift_cnt=0, ir_updated=0.
REQ-031 Load: capture, then 5 shifts with TDI=1,1,1,1,1, then update -> parallel_out=5'b11111; ir_updated=1 for exactly one cycle; tdo_ir sequence during shift=1,0,0,0,0.
REQ-032 Over-shift: capture, then 7 shifts with TDI=0,1,0,1,1,0,0, then update -> parallel_out=5'b00110 (first-shifted bit lands at LSB after 5 shifts); shift_cnt=7.
REQ-033 Priority: capture_ir and update_ir both 1 -> shift_reg=5'b00001, parallel_out unchanged, no ir_updated pulse; tlr with shift_ir -> parallel_out=5'b00001.
REQ-034 Reset mid-op: TRST on shift #3 of a BYPASS (5'b11111) load -> parallel_out stays 5'b00001; the next update without capture latches 5'b00001.
REQ-035 Status capture (IR_CAPTURE_STATUS_EN defined, status_in=3'b101): capture, then 5 shifts with TDI=0 -> tdo_ir=1,0,1,0,1; without the macro -> 1,0,0,0,0.

Source files
------------

// File: rtl/instruction_register_if.sv
// -----------------------------------------------------------------------------
// instruction_register_if
//
// Purpose: groups the TAP-controller-to-instruction-register signals.
//   master : TAP controller side (drives state strobes, TDI, status_in)
//   slave  : instruction register side (drives tdo_ir, parallel_out,
//            ir_updated, shift_cnt)
//
// Signals:
//   tlr, capture_ir, shift_ir, update_ir : TAP state strobes, one-hot in
//                                          normal use, prioritised if not
//   TDI                                  : serial data in
//   status_in [IR_WIDTH-2]               : status captured into the IR (only
//                                          when IR_CAPTURE_STATUS_EN is set)
//   tdo_ir                               : serial data out
//   parallel_out [IR_WIDTH]              : active instruction
//   ir_updated                           : one-cycle "new instruction" pulse
//   shift_cnt [4]                        : bits shifted since capture (sat 15)
// -----------------------------------------------------------------------------
interface instruction_register_if #(
    parameter int IR_WIDTH = 5
);
    logic                tlr;
    logic                capture_ir;
    logic                shift_ir;
    logic                update_ir;
    logic                TDI;
    logic [IR_WIDTH-3:0] status_in;
    logic                tdo_ir;
    logic [IR_WIDTH-1:0] parallel_out;
    logic                ir_updated;
    logic [3:0]          shift_cnt;

    modport master (
        output tlr, capture_ir, shift_ir, update_ir, TDI, status_in,
        input  tdo_ir, parallel_out, ir_updated, shift_cnt
    );

    modport slave (
        input  tlr, capture_ir, shift_ir, update_ir, TDI, status_in,
        output tdo_ir, parallel_out, ir_updated, shift_cnt
    );
endinterface

// File: rtl/instruction_register.sv
// -----------------------------------------------------------------------------
// instruction_register
//
// Purpose: JTAG-style instruction register. A shift stage is captured,
// shifted LSB-first from TDI to tdo_ir, and copied into an update stage that
// holds the active instruction for the decoder.
//
// Parameters:
//   IR_WIDTH    : register length, legal range 3..8 (default 5)
//   RESET_INSTR : instruction loaded on TRST or Test-Logic-Reset
//                 (default 5'b00001, IDCODE)
//
// Ports:
//   TCK  : clock, all state changes on its rising edge
//   TRST : synchronous active-high reset
//   bus  : instruction_register_if.slave (strobes, TDI, status_in in;
//          tdo_ir, parallel_out, ir_updated, shift_cnt out)
//
// Build option:
//   IR_CAPTURE_STATUS_EN : when defined, Capture-IR loads {status_in, 2'b01};
//                          otherwise it loads {zeros, 2'b01} and status_in is
//                          ignored.
//
// Control protocol: the strobes are evaluated once per TCK rising edge with
// fixed priority TRST > tlr > capture_ir > shift_ir > update_ir. Only the
// highest asserted strobe acts; the others are ignored for that edge.
// -----------------------------------------------------------------------------
module instruction_register #(
    parameter int                  IR_WIDTH    = 5,
    parameter logic [IR_WIDTH-1:0] RESET_INSTR = IR_WIDTH'(5'b00001)
) (
    input logic                     TCK,
    input logic                     TRST,
    instruction_register_if.slave   bus
);

    localparam logic [IR_WIDTH-1:0] CAPTURE_ZERO = {{(IR_WIDTH-2){1'b0}}, 2'b01};

    logic [IR_WIDTH-1:0] r_shift_reg;
    logic [IR_WIDTH-1:0] r_upd_reg;
    logic [3:0]          r_shift_cnt;
    logic                r_ir_updated;
    logic                r_update_prev;

    logic                w_do_capture;
    logic                w_do_shift;
    logic                w_do_update;
    logic [IR_WIDTH-1:0] w_capture_val;

    // Priority decode below tlr; TRST and tlr share the reset path.
    assign w_do_capture = bus.capture_ir & ~bus.tlr;
    assign w_do_shift   = bus.shift_ir   & ~bus.tlr & ~bus.capture_ir;
    assign w_do_update  = bus.update_ir  & ~bus.tlr & ~bus.capture_ir & ~bus.shift_ir;

`ifdef IR_CAPTURE_STATUS_EN
    assign w_capture_val = {bus.status_in, 2'b01};
`else
    // status_in is intentionally ignored in this build.
    logic w_unused_status;
    assign w_unused_status = ^bus.status_in;
    assign w_capture_val   = CAPTURE_ZERO;
`endif

    always_ff @(posedge TCK) begin
        if (TRST || bus.tlr) begin
            r_upd_reg     <= RESET_INSTR;
            r_shift_reg   <= CAPTURE_ZERO;
            r_shift_cnt   <= 4'd0;
            r_ir_updated  <= 1'b0;
            r_update_prev <= 1'b0;
        end else begin
            // Pulse only on the first cycle of an (effective) update, so a
            // held update_ir reloads upd_reg but reports once.
            r_ir_updated  <= w_do_update & ~r_update_prev;
            r_update_prev <= w_do_update;

            if (w_do_capture) begin
                r_shift_reg <= w_capture_val;
                r_shift_cnt <= 4'd0;
            end else if (w_do_shift) begin
                r_shift_reg <= {bus.TDI, r_shift_reg[IR_WIDTH-1:1]};
                if (r_shift_cnt != 4'd15) begin
                    r_shift_cnt <= r_shift_cnt + 4'd1;
                end
            end else if (w_do_update) begin
                r_upd_reg <= r_shift_reg;
            end
        end
    end

    // tdo_ir is combinational so the bit is presented before the shift edge.
    assign bus.tdo_ir       = r_shift_reg[0];
    assign bus.parallel_out = r_upd_reg;
    assign bus.ir_updated   = r_ir_updated;
    assign bus.shift_cnt    = r_shift_cnt;

endmodule

// File: tb/tb_instruction_register.sv
// -----------------------------------------------------------------------------
// tb_instruction_register
//
// Self-checking bench for instruction_register (IR_WIDTH = 5). A table of
// per-cycle stimulus records with expected post-edge outputs is applied in a
// loop, followed by hand-written sequences for reset mid-shift, counter
// saturation, reset coincident with update, and capture contents.
// -----------------------------------------------------------------------------
module tb_instruction_register;

    localparam int W = 5;

    // ---------------- clock / reset ----------------
    logic TCK;
    logic TRST;

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    instruction_register_if #(.IR_WIDTH(W)) bus ();

    instruction_register #(
        .IR_WIDTH    (W),
        .RESET_INSTR (5'b00001)
    ) dut (
        .TCK  (TCK),
        .TRST (TRST),
        .bus  (bus)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         trst;
        logic         tlr;
        logic         cap;
        logic         sh;
        logic         up;
        logic         tdi;
        logic         exp_tdo;
        logic [W-1:0] exp_pout;
        logic         exp_upd;
        logic [3:0]   exp_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic trst, input logic tlr, input logic cap,
                                input logic sh, input logic up, input logic tdi,
                                input logic e_tdo, input logic [W-1:0] e_pout,
                                input logic e_upd, input logic [3:0] e_cnt);
        vec_t v;
        v.trst = trst; v.tlr = tlr; v.cap = cap; v.sh = sh; v.up = up; v.tdi = tdi;
        v.exp_tdo = e_tdo; v.exp_pout = e_pout; v.exp_upd = e_upd; v.exp_cnt = e_cnt;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic trst, input logic tlr, input logic cap,
                          input logic sh, input logic up, input logic tdi);
        TRST           = trst;
        bus.tlr        = tlr;
        bus.capture_ir = cap;
        bus.shift_ir   = sh;
        bus.update_ir  = up;
        bus.TDI        = tdi;
    endtask

    task automatic tick();
        @(posedge TCK);
        #1;
    endtask

    task automatic drive(input logic trst, input logic tlr, input logic cap,
                         input logic sh, input logic up, input logic tdi);
        @(negedge TCK);
        set_in(trst, tlr, cap, sh, up, tdi);
        tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "timeout");
    end

    // ---------------- test ----------------
    initial begin
        logic [W-1:0] m_sr;
        logic [3:0]   m_cnt;
        logic         r_tdi;

        set_in(0, 0, 0, 0, 0, 0);
        bus.status_in = 3'b000;

        //              trst tlr cap sh up tdi | tdo pout      upd cnt
        vq.push_back(mk(1, 0, 0, 0, 0, 0,  1, 5'b00001, 0, 4'd0));  // reset
        // load BYPASS: 5 x TDI=1
        vq.push_back(mk(0, 0, 1, 0, 0, 0,  1, 5'b00001, 0, 4'd0));
        vq.push_back(mk(0, 0, 0, 1, 0, 1,  0, 5'b00001, 0, 4'd1));
        vq.push_back(mk(0, 0, 0, 1, 0, 1,  0, 5'b00001, 0, 4'd2));
        vq.push_back(mk(0, 0, 0, 1, 0, 1,  0, 5'b00001, 0, 4'd3));
        vq.push_back(mk(0, 0, 0, 1, 0, 1,  0, 5'b00001, 0, 4'd4));
        vq.push_back(mk(0, 0, 0, 1, 0, 1,  1, 5'b00001, 0, 4'd5));
        vq.push_back(mk(0, 0, 0, 0, 1, 0,  1, 5'b11111, 1, 4'd5));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  1, 5'b11111, 0, 4'd5));
        // over-shift: 7 bits 0,1,0,1,1,0,0
        vq.push_back(mk(0, 0, 1, 0, 0, 0,  1, 5'b11111, 0, 4'd0));
        vq.push_back(mk(0, 0, 0, 1, 0, 0,  0, 5'b11111, 0, 4'd1));
        vq.push_back(mk(0, 0, 0, 1, 0, 1,  0, 5'b11111, 0, 4'd2));
        vq.push_back(mk(0, 0, 0, 1, 0, 0,  0, 5'b11111, 0, 4'd3));
        vq.push_back(mk(0, 0, 0, 1, 0, 1,  0, 5'b11111, 0, 4'd4));
        vq.push_back(mk(0, 0, 0, 1, 0, 1,  0, 5'b11111, 0, 4'd5));
        vq.push_back(mk(0, 0, 0, 1, 0, 0,  1, 5'b11111, 0, 4'd6));
        vq.push_back(mk(0, 0, 0, 1, 0, 0,  0, 5'b11111, 0, 4'd7));
        vq.push_back(mk(0, 0, 0, 0, 1, 0,  0, 5'b00110, 1, 4'd7));
        // update held a second cycle: reload, no second pulse
        vq.push_back(mk(0, 0, 0, 0, 1, 0,  0, 5'b00110, 0, 4'd7));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 5'b00110, 0, 4'd7));
        // capture + update: capture wins, no pulse
        vq.push_back(mk(0, 0, 1, 0, 1, 0,  1, 5'b00110, 0, 4'd0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  1, 5'b00110, 0, 4'd0));
        // tlr + shift: tlr wins
        vq.push_back(mk(0, 1, 0, 1, 0, 1,  1, 5'b00001, 0, 4'd0));
        // partial shift (2 bits) then update
        vq.push_back(mk(0, 0, 1, 0, 0, 0,  1, 5'b00001, 0, 4'd0));
        vq.push_back(mk(0, 0, 0, 1, 0, 1,  0, 5'b00001, 0, 4'd1));
        vq.push_back(mk(0, 0, 0, 1, 0, 0,  0, 5'b00001, 0, 4'd2));
        vq.push_back(mk(0, 0, 0, 0, 1, 0,  0, 5'b01000, 1, 4'd2));
        vq.push_back(mk(0, 0, 0, 0, 0, 0,  0, 5'b01000, 0, 4'd2));
        // shift + update: shift wins
        vq.push_back(mk(0, 0, 0, 1, 1, 1,  0, 5'b01000, 0, 4'd3));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].trst, vq[i].tlr, vq[i].cap, vq[i].sh, vq[i].up, vq[i].tdi);
            check($sformatf("v%0d_tdo", i),  32'(bus.tdo_ir),       32'(vq[i].exp_tdo));
            check($sformatf("v%0d_pout", i), 32'(bus.parallel_out), 32'(vq[i].exp_pout));
            check($sformatf("v%0d_upd", i),  32'(bus.ir_updated),   32'(vq[i].exp_upd));
            check($sformatf("v%0d_cnt", i),  32'(bus.shift_cnt),    32'(vq[i].exp_cnt));
        end

        // ---- TRST on the third shift of a BYPASS load ----
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 0, 1);
        drive(1, 0, 0, 1, 0, 1);
        check("rst_mid_pout", 32'(bus.parallel_out), 32'(5'b00001));
        check("rst_mid_tdo",  32'(bus.tdo_ir),       32'd1);
        check("rst_mid_cnt",  32'(bus.shift_cnt),    32'd0);
        drive(0, 0, 0, 0, 1, 0);
        check("rst_mid_upd_pout", 32'(bus.parallel_out), 32'(5'b00001));
        check("rst_mid_upd_pulse", 32'(bus.ir_updated), 32'd1);
        drive(0, 0, 0, 0, 0, 0);

        // ---- long shift: counter saturation and last-5-bits retention ----
        drive(0, 0, 1, 0, 0, 0);
        m_sr  = 5'b00001;
        m_cnt = 4'd0;
        for (int i = 0; i < 20; i++) begin
            r_tdi = 1'($urandom_range(0, 1));
            drive(0, 0, 0, 1, 0, r_tdi);
            m_sr = {r_tdi, m_sr[W-1:1]};
            if (m_cnt != 4'd15) m_cnt = m_cnt + 4'd1;
            check($sformatf("sat%0d_cnt", i), 32'(bus.shift_cnt), 32'(m_cnt));
            check($sformatf("sat%0d_tdo", i), 32'(bus.tdo_ir),    32'(m_sr[0]));
        end
        drive(0, 0, 0, 0, 1, 0);
        check("sat_pout",  32'(bus.parallel_out), 32'(m_sr));
        check("sat_pulse", 32'(bus.ir_updated),   32'd1);

        // ---- TRST coincident with update: reset wins ----
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 1, 0);
        check("rst_upd_pout",  32'(bus.parallel_out), 32'(5'b00001));
        check("rst_upd_pulse", 32'(bus.ir_updated),   32'd0);
        check("rst_upd_tdo",   32'(bus.tdo_ir),       32'd1);
        drive(0, 0, 0, 0, 0, 0);

        // ---- capture contents, tdo checked before each shift edge ----
        bus.status_in = 3'b101;
        drive(0, 0, 1, 0, 0, 0);
`ifdef IR_CAPTURE_STATUS_EN
        exp_q.push_back(5'd1); exp_q.push_back(5'd0); exp_q.push_back(5'd1);
        exp_q.push_back(5'd0); exp_q.push_back(5'd1);
`else
        exp_q.push_back(5'd1); exp_q.push_back(5'd0); exp_q.push_back(5'd0);
        exp_q.push_back(5'd0); exp_q.push_back(5'd0);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge TCK);
            set_in(0, 0, 0, 1, 0, 0);
            #1;
            check($sformatf("cap_tdo%0d", i), 32'(bus.tdo_ir), 32'(exp_q.pop_front()));
            tick();
        end
        check("cap_pout_kept", 32'(bus.parallel_out), 32'(5'b00001));
        drive(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
